// File: rtl/oric_ram_sched.sv
// rtl/oric_ram_sched.sv - main-RAM port scheduler: clear sweep, CPU bus, loader FIFO (option: ORIC_RAM_PATTERN_EN)
module oric_ram_sched #(
   parameter int         AW       = 16,
   parameter logic [7:0] FILL     = 8'hFF,
   parameter int         LD_DEPTH = 2
) (
   input  logic          clk_sys,
   input  logic          RESET,
   input  logic          clr_req,
   input  logic          cpu_cs,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_ad,
   input  logic [7:0]    cpu_d,
   output logic [7:0]    cpu_q,
   input  logic          ld_wr,
   input  logic [AW-1:0] ld_addr,
   input  logic [7:0]    ld_dout,
   output logic          ld_full,
   output logic          ld_ovf,
   output logic [AW-1:0] ram_addr,
   output logic [7:0]    ram_din,
   output logic          ram_we,
   input  logic [7:0]    ram_q,
   output logic          clearing,
   output logic          clr_done
);

   localparam int          PW          = $clog2(LD_DEPTH);
   localparam logic [PW:0] LD_FULL_CNT = (PW+1)'(LD_DEPTH);

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_RUN   = 1'b1
   } state_t;

   state_t        state;
   state_t        state_nxt;

   // Sweep counter carries one extra bit; it sets when the last location is written.
   logic [AW:0]   sweep_cnt;
   logic [AW:0]   sweep_inc;
   logic          sweep_last;
   logic [7:0]    sweep_byte;
   logic [7:0]    cpu_q_init;

   // Loader posted-write FIFO, entries are {address, data}.
   logic [AW+7:0] ld_mem [LD_DEPTH];
   logic [PW-1:0] ld_wp;
   logic [PW-1:0] ld_rp;
   logic [PW:0]   ld_count;
   logic [PW:0]   ld_count_nxt;
   logic [AW+7:0] ld_head;
   logic          ld_empty;
   logic          ld_pop;
   logic          ld_push;

   // One-cycle delayed marker of a CPU read slot, aligns with BRAM latency.
   logic          cpu_rd_slot;
   logic          rd_slot_d;

   assign sweep_inc  = sweep_cnt + (AW+1)'(1);
   assign sweep_last = sweep_inc[AW];

`ifdef ORIC_RAM_PATTERN_EN
   // Power-on stripes of the real machine: 128-byte bands, inverted in the upper half.
   assign sweep_byte = (sweep_cnt[7] ? 8'hFF : 8'h00) ^ {8{sweep_cnt[AW-1]}};
   assign cpu_q_init = 8'h00;
`else
   assign sweep_byte = FILL;
   assign cpu_q_init = FILL;
`endif

   assign ld_head  = ld_mem[ld_rp];
   assign ld_empty = (ld_count == '0);
   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign ld_push  = ld_wr && ((ld_count != LD_FULL_CNT) || ld_pop);

   // State register.
   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         state <= S_CLEAR;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: sweep ends on its last write unless restarted; clr_req re-enters CLEAR.
   always_comb begin
      state_nxt = state;
      case (state)
         S_CLEAR: begin
            if (!clr_req && sweep_last) begin
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (clr_req) begin
               state_nxt = S_CLEAR;
            end
         end
         default: state_nxt = S_CLEAR;
      endcase
   end

   // RAM port arbitration: sweep owns the port in CLEAR, CPU beats loader in RUN.
   always_comb begin
      ram_addr    = cpu_ad;
      ram_din     = cpu_d;
      ram_we      = 1'b0;
      ld_pop      = 1'b0;
      cpu_rd_slot = 1'b0;
      case (state)
         S_CLEAR: begin
            ram_addr = sweep_cnt[AW-1:0];
            ram_din  = sweep_byte;
            ram_we   = 1'b1;
         end
         S_RUN: begin
            if (cpu_cs) begin
               ram_we      = cpu_we;
               cpu_rd_slot = !cpu_we;
            end else if (!ld_empty) begin
               ram_addr = ld_head[AW+7:8];
               ram_din  = ld_head[7:0];
               ram_we   = 1'b1;
               ld_pop   = 1'b1;
            end
         end
         default: begin
            ram_we = 1'b0;
         end
      endcase
   end

   // Sweep counter: advances in CLEAR, restarts on clr_req, parked at zero in RUN.
   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         sweep_cnt <= '0;
      end else if (state == S_CLEAR) begin
         if (clr_req) begin
            sweep_cnt <= '0;
         end else begin
            sweep_cnt <= sweep_inc;
         end
      end else begin
         sweep_cnt <= '0;
      end
   end

   // Sweep status flags, registered so clr_done and the clearing drop share a cycle.
   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         clearing <= 1'b1;
         clr_done <= 1'b0;
      end else begin
         clearing <= (state_nxt == S_CLEAR);
         clr_done <= (state == S_CLEAR) && (state_nxt == S_RUN);
      end
   end

   // FIFO storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clk_sys) begin
      if (ld_push) begin
         ld_mem[ld_wp] <= {ld_addr, ld_dout};
      end
   end

   // Occupancy after this cycle's push and pop.
   always_comb begin
      ld_count_nxt = ld_count;
      if (ld_push && !ld_pop) begin
         ld_count_nxt = ld_count + (PW+1)'(1);
      end else if (!ld_push && ld_pop) begin
         ld_count_nxt = ld_count - (PW+1)'(1);
      end
   end

   // FIFO pointers, full flag and sticky overflow; only RESET flushes them.
   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         ld_wp    <= '0;
         ld_rp    <= '0;
         ld_count <= '0;
         ld_full  <= 1'b0;
         ld_ovf   <= 1'b0;
      end else begin
         if (ld_push) begin
            ld_wp <= ld_wp + PW'(1);
         end
         if (ld_pop) begin
            ld_rp <= ld_rp + PW'(1);
         end
         ld_count <= ld_count_nxt;
         ld_full  <= (ld_count_nxt == LD_FULL_CNT);
         if (ld_wr && !ld_push) begin
            ld_ovf <= 1'b1;
         end
      end
   end

   // CPU read data: capture BRAM output one cycle after a read slot, hold otherwise.
   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         rd_slot_d <= 1'b0;
         cpu_q     <= cpu_q_init;
      end else begin
         rd_slot_d <= cpu_rd_slot;
         if (rd_slot_d) begin
            cpu_q <= ram_q;
         end
      end
   end

endmodule

// File: doc/oric_ram_sched.md
Name: oric_ram_sched

Overview:
Scheduler for the single-port 64 KB main-RAM block RAM. It sequences three requesters onto one RAM port:
- a power-on/reset clear sweep;
- the CPU/ULA bus from the machine core;
- a host byte loader (ioctl-style) that injects program images into RAM.

It sits between the machine core and the RAM array, owns the RAM address/data/write-enable, and returns read data to the core.

Parameters:
- AW, 16: RAM address width; the array holds 2^AW bytes.
- FILL, 8'hFF: byte written to every location during a clear sweep.
- LD_DEPTH, 2: depth of the loader posted-write FIFO; a power of two, minimum 2.

Ports:
- clk_sys  in  1  system clock.
- RESET  in  1  synchronous, active-high reset; clock clk_sys. Also starts a clear sweep.
- clr_req  in  1  single-cycle pulse; starts a clear sweep without a full reset.
- cpu_cs  in  1  core RAM select.
- cpu_we  in  1  core write strobe; qualified by cpu_cs.
- cpu_ad  in  AW  core address.
- cpu_d  in  8  core write data.
- cpu_q  out  8  read data to the core; registered.
- ld_wr  in  1  loader byte strobe.
- ld_addr  in  AW  loader address.
- ld_dout  in  8  loader data.
- ld_full  out  1  loader FIFO full.
- ld_ovf  out  1  sticky: a loader byte was dropped.
- ram_addr  out  AW  RAM address.
- ram_din  out  8  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_q  in  8  RAM read data; one-cycle BRAM latency.
- clearing  out  1  high while a sweep is in progress.
- clr_done  out  1  one-cycle pulse when a sweep completes.

Behaviour:
- States: CLEAR, RUN.
- Reset values:
  - state=CLEAR, sweep counter=0, clearing=1.
  - cpu_q=FILL.
  - FIFO empty, ld_full=0, ld_ovf=0, clr_done=0.
- CLEAR:
  - One write per cycle: ram_addr=counter, ram_din=FILL, ram_we=1.
  - Counter increments from 0 to 2^AW-1. Total is exactly 2^AW write cycles after RESET deasserts.
  - On the cycle that writes 2^AW-1: the next state is RUN, clr_done pulses for one cycle in the first RUN cycle, and clearing drops at the same time.
  - CPU accesses are ignored. cpu_q holds FILL.
  - ld_wr bytes are queued into the FIFO. Overflow rules below apply.
- RESET held high: state stays CLEAR, counter stays 0.
- RESET or clr_req mid-sweep: counter restarts at 0. A RESET also flushes the FIFO and clears ld_ovf; clr_req does neither.
- clr_req in RUN: enters CLEAR on the next cycle. An in-flight loader write in that cycle still completes.
- RUN priority: the CPU has absolute priority.
  - cpu_cs=1: ram_addr=cpu_ad, ram_din=cpu_d, ram_we=cpu_we.
  - cpu_cs=0 and FIFO non-empty: pop the head entry and write it (ram_we=1).
  - Otherwise: ram_addr=cpu_ad, ram_we=0.
- cpu_q: registered from ram_q in the cycle after a CPU read slot (cpu_cs=1, cpu_we=0). It holds its value otherwise. Read latency to cpu_q is 2 cycles from cpu_ad.
- FIFO:
  - Push on ld_wr; entry is {ld_addr, ld_dout}.
  - ld_full = (count == LD_DEPTH).
  - Simultaneous push and pop while full: accepted, count unchanged.
  - Push while full with no pop: byte dropped, ld_ovf set. ld_ovf is cleared only by RESET.
- Hazard: a CPU read of an address whose write is still queued returns old RAM data. The loader host is responsible for ordering.
- Address arithmetic:
  - The sweep counter is AW+1 bits; its MSB marks completion.
  - FIFO pointers are log2(LD_DEPTH) bits and wrap modulo LD_DEPTH.
- Combinational outputs: ram_addr, ram_din, ram_we. All other outputs are registered.

Optional Feature:
ORIC_RAM_PATTERN_EN
- Defined: the sweep writes the power-on pattern of the real machine: ram_din = (counter[7] ? 8'hFF : 8'h00) ^ {8{counter[AW-1]}}. FILL is unused and cpu_q resets to 8'h00.
- Undefined: every location gets FILL.

Test Plan:
- RESET 1 cycle, AW=16: clearing=1 for 65536 cycles, ram_we=1 each cycle, last write at 16'hFFFF with ram_din=8'hFF, then clr_done pulses once and clearing=0.
- RUN, cpu_cs=1, cpu_we=1 to 16'h1234 with 8'hA5, then a read of 16'h1234: cpu_q=8'hA5 two cycles after the read address is applied.
- ld_wr to 16'h0500 with 8'h3C while cpu_cs=1 for 3 cycles: no RAM write until cpu_cs=0, then exactly one write at 16'h0500 with 8'h3C.
- LD_DEPTH=2, cpu_cs held high, three ld_wr strobes: ld_full=1 after the second, third byte dropped, ld_ovf=1; after cpu_cs=0 exactly two writes occur, in order.
- clr_req at counter=16'h4000: the next cycle writes address 0, and the sweep completes 65536 cycles later with a single clr_done.
- ORIC_RAM_PATTERN_EN defined: after the sweep, reads of 16'h0000, 16'h0080, and 16'h8000 return 8'h00, 8'hFF, and 8'hFF.
